// File: rtl/outer_product_stream.sv
// Buffers VEC_LEN-element vectors A and B, then streams all A[i]*B[j] products (row- or column-major).
// First product is registered one cycle after the last input beat; out_ready low freezes the output.
module outer_product_stream #(
  parameter int DATA_W  = 4,
  parameter int VEC_LEN = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mode,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_last
);

  localparam int CW = $clog2(VEC_LEN);
  localparam int PW = 2 * DATA_W;
  localparam logic [CW-1:0] LAST_IDX = CW'(VEC_LEN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] a_mem [VEC_LEN];
  logic [DATA_W-1:0] b_mem [VEC_LEN];
  logic [CW-1:0]     k;
  logic [CW-1:0]     outer, inner;
  logic [CW-1:0]     outer_nxt, inner_nxt;
  logic [CW-1:0]     row_nxt, col_nxt;
  logic [1:0]        mode;
  logic              in_fire, out_fire, load_done, last_nxt;
  logic [DATA_W-1:0] op_a, op_b;
  logic [PW-1:0]     ext_a, ext_b, prod_nxt;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign load_done = in_fire && (state == LOAD) && (k == LAST_IDX);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (k == LAST_IDX)) state_nxt = STREAM;
      end
      STREAM: begin
        if (out_fire && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Index of the product to present next; outside STREAM this is the first product.
  always_comb begin
    outer_nxt = '0;
    inner_nxt = '0;
    if (state == STREAM) begin
      if (inner == LAST_IDX) begin
        inner_nxt = '0;
        outer_nxt = outer + 1'b1;
      end else begin
        inner_nxt = inner + 1'b1;
        outer_nxt = outer;
      end
    end
  end

  // Transposed order swaps which loop counter selects the A row.
  assign row_nxt  = mode[0] ? inner_nxt : outer_nxt;
  assign col_nxt  = mode[0] ? outer_nxt : inner_nxt;
  assign op_a     = a_mem[row_nxt];
  assign op_b     = b_mem[col_nxt];
  assign ext_a    = mode[1] ? {{DATA_W{op_a[DATA_W-1]}}, op_a} : {{DATA_W{1'b0}}, op_a};
  assign ext_b    = mode[1] ? {{DATA_W{op_b[DATA_W-1]}}, op_b} : {{DATA_W{1'b0}}, op_b};
  assign prod_nxt = ext_a * ext_b;
  assign last_nxt = (outer_nxt == LAST_IDX) && (inner_nxt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      outer     <= '0;
      inner     <= '0;
      mode      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        a_mem[k] <= in_a;
        b_mem[k] <= in_b;
        k        <= (k == LAST_IDX) ? '0 : k + 1'b1;
        if (state == IDLE) mode <= in_mode;
      end
      if (load_done || (out_fire && !out_last)) begin
        outer     <= outer_nxt;
        inner     <= inner_nxt;
        out_valid <= 1'b1;
        out_data  <= prod_nxt;
        out_last  <= last_nxt;
      end else if (out_fire) begin
        outer     <= '0;
        inner     <= '0;
        out_valid <= 1'b0;
        out_data  <= '0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_outer_product_stream.sv
// Bench for outer_product_stream: a 4-bit/16-element instance and an 8-bit/5-element instance,
// random stimulus compared against a plain-arithmetic product model.
module tb_outer_product_stream;

  logic       clk;
  logic       rst;

  logic       in_valid0, in_ready0, out_valid0, out_ready0, out_last0;
  logic [1:0] in_mode0;
  logic [3:0] in_a0, in_b0;
  logic [7:0] out_data0;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, out_last1;
  logic [1:0]  in_mode1;
  logic [7:0]  in_a1, in_b1;
  logic [15:0] out_data1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  va [16];
  logic [7:0]  vb [16];
  logic [15:0] cap_d [$];
  logic        cap_l [$];
  int          stall_viol, rdy_viol, timeout;
  logic        lat_ok, post_valid, post_ready;
  logic [15:0] post_data;

  outer_product_stream dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_mode(in_mode0),
    .in_a(in_a0), .in_b(in_b0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_last(out_last0)
  );

  outer_product_stream #(.DATA_W(8), .VEC_LEN(5)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_mode(in_mode1),
    .in_a(in_a1), .in_b(in_b1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_last(out_last1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required completion)", $time);
    $fatal(1);
  end

  task automatic drive_in(input int sel, input logic v, input logic [1:0] m,
                          input logic [7:0] a, input logic [7:0] b);
    if (sel == 0) begin
      in_valid0 = v; in_mode0 = m; in_a0 = a[3:0]; in_b0 = b[3:0];
    end else begin
      in_valid1 = v; in_mode1 = m; in_a1 = a; in_b1 = b;
    end
  endtask

  task automatic drive_ordy(input int sel, input logic r);
    if (sel == 0) out_ready0 = r;
    else          out_ready1 = r;
  endtask

  task automatic read_out(input int sel, output logic v, output logic [15:0] d,
                          output logic l, output logic ir);
    if (sel == 0) begin
      v = out_valid0; d = {8'h00, out_data0}; l = out_last0; ir = in_ready0;
    end else begin
      v = out_valid1; d = out_data1; l = out_last1; ir = in_ready1;
    end
  endtask

  // Product C[i][j] for the p-th output beat, straight from the ordering and arithmetic rules.
  function automatic logic [15:0] model(input int sel, input logic [1:0] m, input int p);
    int n, w, oi, ii, i, j, x, y, pr;
    n  = (sel == 0) ? 16 : 5;
    w  = (sel == 0) ? 4 : 8;
    oi = p / n;
    ii = p % n;
    i  = m[0] ? ii : oi;
    j  = m[0] ? oi : ii;
    x  = int'(va[i]);
    y  = int'(vb[j]);
    if (m[1]) begin
      if (x >= (1 << (w - 1))) x -= (1 << w);
      if (y >= (1 << (w - 1))) y -= (1 << w);
    end
    pr = x * y;
    return 16'(pr & ((1 << (2 * w)) - 1));
  endfunction

  task automatic fill_random(input int sel);
    for (int q = 0; q < 16; q++) begin
      va[q] = (sel == 0) ? 8'($urandom_range(15)) : 8'($urandom_range(255));
      vb[q] = (sel == 0) ? 8'($urandom_range(15)) : 8'($urandom_range(255));
    end
  endtask

  // Loads one frame (later beats carry junk mode bits) and collects every retired output beat.
  task automatic run_frame(input int sel, input logic [1:0] mode, input int gap_pct,
                           input int stall_pct, input bit junk);
    int n, k, budget;
    logic v, l, ir, r, vv, fire, done, pstall, pl;
    logic [15:0] d, pd;
    n = (sel == 0) ? 16 : 5;
    cap_d.delete();
    cap_l.delete();
    stall_viol = 0; rdy_viol = 0; timeout = 0;
    k = 0; budget = 0;
    drive_ordy(sel, 1'b0);
    while (k < n && budget < 1000) begin
      vv = ($urandom_range(99) >= gap_pct);
      drive_in(sel, vv, (k == 0) ? mode : 2'($urandom), va[k], vb[k]);
      read_out(sel, v, d, l, ir);
      fire = vv && ir;
      @(posedge clk); #1;
      if (fire) k++;
      budget++;
    end
    if (k < n) timeout = 1;
    drive_in(sel, 1'b0, 2'b00, 8'h00, 8'h00);
    read_out(sel, v, d, l, ir);
    lat_ok = v;
    done = 0; pstall = 0; pl = 0; pd = '0; budget = 0;
    while (!done && budget < 2000) begin
      r = ($urandom_range(99) >= stall_pct);
      drive_ordy(sel, r);
      if (junk) drive_in(sel, 1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
      read_out(sel, v, d, l, ir);
      if (ir) rdy_viol++;
      if (pstall && (d !== pd || l !== pl || v !== 1'b1)) stall_viol++;
      pstall = v && !r;
      pd = d; pl = l;
      if (v && r) begin
        cap_d.push_back(d);
        cap_l.push_back(l);
        if (l) done = 1;
      end
      @(posedge clk); #1;
      budget++;
    end
    if (!done) timeout = 1;
    drive_in(sel, 1'b0, 2'b00, 8'h00, 8'h00);
    drive_ordy(sel, 1'b0);
    read_out(sel, post_valid, post_data, l, post_ready);
  endtask

  task automatic test_reset();
    int hits;
    // Reset state of both instances while rst is held.
    n_cmp++;
    if (out_valid0 !== 1'b0 || out_data0 !== 8'h00 || out_last0 !== 1'b0 || in_ready0 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state0: got v=%b d=%h l=%b rdy=%b, need 0 00 0 1",
               out_valid0, out_data0, out_last0, in_ready0);
    end
    n_cmp++;
    if (out_valid1 !== 1'b0 || out_data1 !== 16'h0000 || out_last1 !== 1'b0 || in_ready1 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state1: got v=%b d=%h l=%b rdy=%b, need 0 0000 0 1",
               out_valid1, out_data1, out_last1, in_ready1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    // Drive into STREAM, retire a few beats, then reset for two cycles.
    out_ready0 = 1'b1;
    for (int q = 0; q < 16; q++) begin
      drive_in(0, 1'b1, 2'b00, 8'($urandom_range(1, 15)), 8'($urandom_range(1, 15)));
      @(posedge clk); #1;
    end
    drive_in(0, 1'b0, 2'b00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid0 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_pre_stream: out_valid=%b, need 1", out_valid0);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (out_valid0 !== 1'b0 || out_data0 !== 8'h00 || in_ready0 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_stream: got v=%b d=%h rdy=%b, need 0 00 1", out_valid0, out_data0, in_ready0);
    end
    hits = 0;
    for (int q = 0; q < 20; q++) begin
      @(posedge clk); #1;
      if (out_valid0 !== 1'b0 || out_data0 !== 8'h00) hits++;
    end
    n_cmp++;
    if (hits != 0) begin
      n_bad++;
      $display("FAIL reset_no_stale: %0d cycles with output after reset, need 0", hits);
    end
    out_ready0 = 1'b0;
  endtask

  task automatic test_unsigned_max();
    int bad_d, bad_l;
    for (int q = 0; q < 16; q++) begin va[q] = 8'd15; vb[q] = 8'd15; end
    run_frame(0, 2'b00, 0, 0, 0);
    n_cmp++;
    if (timeout != 0 || cap_d.size() != 256) begin
      n_bad++;
      $display("FAIL max_count: timeout=%0d beats=%0d, need 0 and 256", timeout, cap_d.size());
    end
    n_cmp++;
    if (lat_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL max_latency: out_valid=%b one cycle after last input, need 1", lat_ok);
    end
    bad_d = 0; bad_l = 0;
    for (int p = 0; p < cap_d.size(); p++) begin
      if (cap_d[p] !== 16'd225) bad_d++;
      if (cap_l[p] !== (p == 255)) bad_l++;
    end
    n_cmp++;
    if (bad_d != 0) begin
      n_bad++;
      $display("FAIL max_data: %0d beats differ from 225 (first=%0d), need 0", bad_d, cap_d[0]);
    end
    n_cmp++;
    if (bad_l != 0) begin
      n_bad++;
      $display("FAIL max_last: %0d beats with wrong out_last, need 0", bad_l);
    end
    n_cmp++;
    if (post_valid !== 1'b0 || post_data !== 16'h0 || post_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL max_idle: got v=%b d=%h rdy=%b after last, need 0 0 1", post_valid, post_data, post_ready);
    end
  endtask

  task automatic test_signed();
    int bad;
    fill_random(0);
    va[0] = 8'h8; vb[0] = 8'h8; vb[1] = 8'h7;
    run_frame(0, 2'b10, 0, 0, 0);
    n_cmp++;
    if (cap_d.size() != 256 || cap_d[0] !== 16'h0040) begin
      n_bad++;
      $display("FAIL signed_c00: got %h (beats=%0d), need 0040", cap_d[0], cap_d.size());
    end
    n_cmp++;
    if (cap_d.size() < 2 || cap_d[1] !== 16'h00C8) begin
      n_bad++;
      $display("FAIL signed_c01: got %h, need 00c8", cap_d[1]);
    end
    bad = 0;
    for (int p = 0; p < cap_d.size(); p++)
      if (cap_d[p] !== model(0, 2'b10, p)) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL signed_frame: %0d beats differ from model, need 0", bad);
    end
  endtask

  task automatic test_transpose();
    int bad;
    for (int q = 0; q < 16; q++) begin va[q] = 8'(q); vb[q] = 8'((q + 1) & 15); end
    run_frame(0, 2'b01, 0, 0, 0);
    n_cmp++;
    if (cap_d.size() != 256 || cap_d[0] !== 16'd0 || cap_d[1] !== 16'd1 || cap_d[2] !== 16'd2) begin
      n_bad++;
      $display("FAIL transpose_head: got %0d %0d %0d (beats=%0d), need 0 1 2",
               cap_d[0], cap_d[1], cap_d[2], cap_d.size());
    end
    n_cmp++;
    if (cap_d.size() < 17 || cap_d[16] !== 16'd0 || cap_d[17] !== 16'd2) begin
      n_bad++;
      $display("FAIL transpose_col1: got beat17=%0d beat18=%0d, need 0 2", cap_d[16], cap_d[17]);
    end
    bad = 0;
    for (int p = 0; p < cap_d.size(); p++)
      if (cap_d[p] !== model(0, 2'b01, p)) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL transpose_frame: %0d beats differ from model, need 0", bad);
    end
  endtask

  task automatic test_random_stall();
    int bad;
    logic [1:0] m;
    for (int f = 0; f < 4; f++) begin
      fill_random(0);
      m = 2'($urandom);
      run_frame(0, m, 30, 50, 1);
      bad = 0;
      for (int p = 0; p < cap_d.size(); p++)
        if (cap_d[p] !== model(0, m, p) || cap_l[p] !== (p == 255)) bad++;
      n_cmp++;
      if (timeout != 0 || cap_d.size() != 256 || bad != 0 || lat_ok !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_frame%0d: mode=%0d timeout=%0d beats=%0d bad=%0d lat=%b, need 0 256 0 1",
                 f, m, timeout, cap_d.size(), bad, lat_ok);
      end
      n_cmp++;
      if (stall_viol != 0 || rdy_viol != 0) begin
        n_bad++;
        $display("FAIL stall_hold%0d: unstable=%0d in_ready_high=%0d, need 0 0", f, stall_viol, rdy_viol);
      end
    end
  endtask

  task automatic test_back_to_back_param();
    int bad_frames, bad;
    logic [1:0] m;
    bad_frames = 0;
    for (int f = 0; f < 200; f++) begin
      fill_random(1);
      m = 2'($urandom);
      run_frame(1, m, 20, 30, f[0]);
      bad = 0;
      for (int p = 0; p < cap_d.size(); p++)
        if (cap_d[p] !== model(1, m, p) || cap_l[p] !== (p == 24)) bad++;
      n_cmp++;
      if (timeout != 0 || cap_d.size() != 25 || bad != 0 || lat_ok !== 1'b1 ||
          stall_viol != 0 || rdy_viol != 0) begin
        n_bad++;
        bad_frames++;
        if (bad_frames <= 5)
          $display("FAIL param_frame%0d: mode=%0d timeout=%0d beats=%0d bad=%0d lat=%b hold=%0d rdy=%0d, need 0 25 0 1 0 0",
                   f, m, timeout, cap_d.size(), bad, lat_ok, stall_viol, rdy_viol);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_in(0, 1'b0, 2'b00, 8'h00, 8'h00);
    drive_in(1, 1'b0, 2'b00, 8'h00, 8'h00);
    out_ready0 = 1'b0;
    out_ready1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_unsigned_max();
    test_signed();
    test_transpose();
    test_random_stall();
    test_back_to_back_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
